// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and grant selection for the two-port memory arbiter.
package mem_arbiter_pkg;

   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_WAIT = 1'b1
   } arb_state_t;

   // A lone full slot always wins; on a conflict either port1 wins (dprio) or the port that was not served last.
   function automatic logic pick_grant(input logic full0, input logic full1,
                                       input logic last_grant, input logic dprio);
      if (full0 && full1) return dprio ? 1'b1 : ~last_grant;
      return full1;
   endfunction

endpackage

// File: rtl/mem_arbiter_slot.sv
// One-entry request slot: captures a pulsed request, frees on completion, flags dropped requests.
module mem_arb_slot
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req_flag,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_w_data,
   input  logic [DATA_WIDTH/8-1:0] req_w_mask,
   input  logic                    free,
   output logic                    full,
   output logic [1:0]              flag,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic [DATA_WIDTH-1:0]   w_data,
   output logic [DATA_WIDTH/8-1:0] w_mask,
   output logic                    overflow
);

   logic req_seen;
   logic capture;

   assign req_seen = (req_flag != RW_NONE);
   assign capture  = req_seen && (!full || free);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (free) full <= 1'b0;
         if (capture) full <= 1'b1;
         if (req_seen && full && !free) overflow <= 1'b1;
      end
   end

   // Payload needs no reset: it is only observed while full is set.
   always_ff @(posedge clk) begin
      if (capture) begin
         flag   <= req_flag[0] ? RW_READ : RW_WRITE;
         addr   <= req_addr;
         w_data <= req_w_data;
         w_mask <= req_w_mask;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory port between icache (port0) and dcache (port1).
// Define MEM_ARB_DPRIO_EN for fixed port1 priority instead of round-robin.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              p0_rw_flag_i,
   input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
   input  logic [DATA_WIDTH-1:0]   p0_w_data_i,
   input  logic [DATA_WIDTH/8-1:0] p0_w_mask_i,
   output logic [DATA_WIDTH-1:0]   p0_r_data_o,
   output logic                    p0_busy_o,
   output logic                    p0_done_o,
   input  logic [1:0]              p1_rw_flag_i,
   input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
   input  logic [DATA_WIDTH-1:0]   p1_w_data_i,
   input  logic [DATA_WIDTH/8-1:0] p1_w_mask_i,
   output logic [DATA_WIDTH-1:0]   p1_r_data_o,
   output logic                    p1_busy_o,
   output logic                    p1_done_o,
   output logic [1:0]              mem_rw_flag_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_w_data_o,
   output logic [DATA_WIDTH/8-1:0] mem_w_mask_o,
   input  logic [DATA_WIDTH-1:0]   mem_r_data_i,
   input  logic                    mem_busy,
   input  logic                    mem_done,
   output logic                    overflow_o
);

`ifdef MEM_ARB_DPRIO_EN
   localparam logic DPRIO = 1'b1;
`else
   localparam logic DPRIO = 1'b0;
`endif

   logic                    s0_full, s1_full;
   logic [1:0]              s0_flag, s1_flag;
   logic [ADDR_WIDTH-1:0]   s0_addr, s1_addr;
   logic [DATA_WIDTH-1:0]   s0_w_data, s1_w_data;
   logic [DATA_WIDTH/8-1:0] s0_w_mask, s1_w_mask;
   logic                    s0_ovf, s1_ovf;
   logic                    free0, free1;

   arb_state_t state;
   logic       last_grant;
   logic       grant_q;
   logic       presented;
   logic       grant;
   logic       any_full;

   assign any_full   = s0_full || s1_full;
   assign free0      = (state == ARB_WAIT) && mem_done && !grant_q;
   assign free1      = (state == ARB_WAIT) && mem_done && grant_q;
   assign p0_busy_o  = s0_full;
   assign p1_busy_o  = s1_full;
   assign overflow_o = s0_ovf || s1_ovf;

   mem_arb_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot0 (
      .clk(clk), .rst(rst),
      .req_flag(p0_rw_flag_i), .req_addr(p0_addr_i),
      .req_w_data(p0_w_data_i), .req_w_mask(p0_w_mask_i),
      .free(free0), .full(s0_full), .flag(s0_flag), .addr(s0_addr),
      .w_data(s0_w_data), .w_mask(s0_w_mask), .overflow(s0_ovf)
   );

   mem_arb_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot1 (
      .clk(clk), .rst(rst),
      .req_flag(p1_rw_flag_i), .req_addr(p1_addr_i),
      .req_w_data(p1_w_data_i), .req_w_mask(p1_w_mask_i),
      .free(free1), .full(s1_full), .flag(s1_flag), .addr(s1_addr),
      .w_data(s1_w_data), .w_mask(s1_w_mask), .overflow(s1_ovf)
   );

   // Once a request is shown to a busy memory, the grant is frozen until it is accepted.
   always_comb begin
      grant = presented ? grant_q : pick_grant(s0_full, s1_full, last_grant, DPRIO);
      mem_rw_flag_o = RW_NONE;
      mem_addr_o    = '0;
      mem_w_data_o  = '0;
      mem_w_mask_o  = '0;
      if (state == ARB_IDLE && any_full) begin
         if (grant) begin
            mem_rw_flag_o = s1_flag;
            mem_addr_o    = s1_addr;
            mem_w_data_o  = s1_w_data;
            mem_w_mask_o  = s1_w_mask;
         end else begin
            mem_rw_flag_o = s0_flag;
            mem_addr_o    = s0_addr;
            mem_w_data_o  = s0_w_data;
            mem_w_mask_o  = s0_w_mask;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ARB_IDLE;
         last_grant  <= 1'b1;
         grant_q     <= 1'b0;
         presented   <= 1'b0;
         p0_done_o   <= 1'b0;
         p1_done_o   <= 1'b0;
         p0_r_data_o <= '0;
         p1_r_data_o <= '0;
      end else begin
         p0_done_o <= 1'b0;
         p1_done_o <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (any_full) begin
                  grant_q <= grant;
                  if (!mem_busy) begin
                     last_grant <= grant;
                     presented  <= 1'b0;
                     state      <= ARB_WAIT;
                  end else begin
                     presented  <= 1'b1;
                  end
               end
            end
            ARB_WAIT: begin
               if (mem_done) begin
                  if (grant_q) begin
                     p1_done_o <= 1'b1;
                     if (s1_flag == RW_READ) p1_r_data_o <= mem_r_data_i;
                  end else begin
                     p0_done_o <= 1'b1;
                     if (s0_flag == RW_READ) p0_r_data_o <= mem_r_data_i;
                  end
                  state <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus hand sequences for busy-hold and reset-in-WAIT.
module tb_mem_arbiter;

`ifdef MEM_ARB_DPRIO_EN
   localparam logic DP = 1'b1;
`else
   localparam logic DP = 1'b0;
`endif

   localparam logic [1:0] NO = 2'b00;
   localparam logic [1:0] RD = 2'b01;
   localparam logic [1:0] WR = 2'b10;
   localparam logic [31:0] Z = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  p0_rw_flag_i, p1_rw_flag_i;
   logic [31:0] p0_addr_i, p1_addr_i, p0_w_data_i, p1_w_data_i;
   logic [3:0]  p0_w_mask_i, p1_w_mask_i;
   logic [31:0] p0_r_data_o, p1_r_data_o;
   logic        p0_busy_o, p1_busy_o, p0_done_o, p1_done_o;
   logic [1:0]  mem_rw_flag_o;
   logic [31:0] mem_addr_o, mem_w_data_o, mem_r_data_i;
   logic [3:0]  mem_w_mask_o;
   logic        mem_busy, mem_done, overflow_o;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .p0_rw_flag_i(p0_rw_flag_i), .p0_addr_i(p0_addr_i), .p0_w_data_i(p0_w_data_i),
      .p0_w_mask_i(p0_w_mask_i), .p0_r_data_o(p0_r_data_o), .p0_busy_o(p0_busy_o),
      .p0_done_o(p0_done_o),
      .p1_rw_flag_i(p1_rw_flag_i), .p1_addr_i(p1_addr_i), .p1_w_data_i(p1_w_data_i),
      .p1_w_mask_i(p1_w_mask_i), .p1_r_data_o(p1_r_data_o), .p1_busy_o(p1_busy_o),
      .p1_done_o(p1_done_o),
      .mem_rw_flag_o(mem_rw_flag_o), .mem_addr_o(mem_addr_o), .mem_w_data_o(mem_w_data_o),
      .mem_w_mask_o(mem_w_mask_o), .mem_r_data_i(mem_r_data_i), .mem_busy(mem_busy),
      .mem_done(mem_done), .overflow_o(overflow_o)
   );

   // ctl = {rst, mem_busy, mem_done}; edb = {p0_done, p1_done, p0_busy, p1_busy}
   typedef struct {
      logic [2:0]  ctl;
      logic [1:0]  f0;
      logic [31:0] a0;
      logic [1:0]  f1;
      logic [31:0] a1;
      logic [31:0] wd1;
      logic [3:0]  m1;
      logic [31:0] rd;
      logic [1:0]  ef;
      logic [31:0] ea;
      logic [31:0] ewd;
      logic [3:0]  em;
      logic [3:0]  edb;
      logic [31:0] er0;
      logic [31:0] er1;
      logic        eovf;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p0_rw_flag_i = NO; p0_addr_i = Z; p0_w_data_i = Z; p0_w_mask_i = 4'h0;
      p1_rw_flag_i = NO; p1_addr_i = Z; p1_w_data_i = Z; p1_w_mask_i = 4'h0;
      mem_busy = 1'b0; mem_done = 1'b0; mem_r_data_i = Z;
   endtask

   task automatic chk_mem(input string tag, input logic [1:0] f, input logic [31:0] a);
      chk({tag, "_flag"}, 32'(mem_rw_flag_o), 32'(f));
      chk({tag, "_addr"}, mem_addr_o, a);
   endtask

   logic [31:0] r9, r11;

   initial begin
      idle_inputs();
      rst = 1'b1;
      #12;
      chk("reset_mem_flag", 32'(mem_rw_flag_o), 32'h0);
      chk("reset_outs", 32'({p0_done_o, p1_done_o, p0_busy_o, p1_busy_o, overflow_o}), 32'h0);
      rst = 1'b0;
      tick();

      r9  = DP ? Z : 32'h11111111;
      r11 = DP ? 32'hAAAAAAAA : 32'h11111111;
      // single read, then conflict after reset, overflow, capture on done, free+capture, 11 as read, spurious done
      tbl.push_back('{3'b000, RD, 32'h40, NO, Z, Z, 4'h0, Z, RD, 32'h40, Z, 4'h0, 4'b0010, Z, Z, 1'b0});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0010, Z, Z, 1'b0});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0010, Z, Z, 1'b0});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0010, Z, Z, 1'b0});
      tbl.push_back('{3'b001, NO, Z, NO, Z, Z, 4'h0, 32'hDEADBEEF, NO, Z, Z, 4'h0, 4'b1000, 32'hDEADBEEF, Z, 1'b0});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0000, 32'hDEADBEEF, Z, 1'b0});
      tbl.push_back('{3'b100, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0000, Z, Z, 1'b0});
      tbl.push_back('{3'b000, RD, 32'h40, WR, 32'h80, 32'h12345678, 4'hF, Z,
                      DP ? WR : RD, DP ? 32'h80 : 32'h40, DP ? 32'h12345678 : Z, DP ? 4'hF : 4'h0,
                      4'b0011, Z, Z, 1'b0});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0011, Z, Z, 1'b0});
      tbl.push_back('{3'b001, NO, Z, NO, Z, Z, 4'h0, 32'h11111111,
                      DP ? RD : WR, DP ? 32'h40 : 32'h80, DP ? Z : 32'h12345678, DP ? 4'h0 : 4'hF,
                      DP ? 4'b0110 : 4'b1001, r9, Z, 1'b0});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, DP ? 4'b0010 : 4'b0001, r9, Z, 1'b0});
      tbl.push_back('{3'b001, NO, Z, NO, Z, Z, 4'h0, 32'hAAAAAAAA, NO, Z, Z, 4'h0,
                      DP ? 4'b1000 : 4'b0100, r11, Z, 1'b0});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0000, r11, Z, 1'b0});
      tbl.push_back('{3'b000, RD, 32'h40, NO, Z, Z, 4'h0, Z, RD, 32'h40, Z, 4'h0, 4'b0010, r11, Z, 1'b0});
      tbl.push_back('{3'b000, RD, 32'h44, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0010, r11, Z, 1'b1});
      tbl.push_back('{3'b001, NO, Z, NO, Z, Z, 4'h0, 32'h55555555, NO, Z, Z, 4'h0, 4'b1000, 32'h55555555, Z, 1'b1});
      tbl.push_back('{3'b000, RD, 32'h60, NO, Z, Z, 4'h0, Z, RD, 32'h60, Z, 4'h0, 4'b0010, 32'h55555555, Z, 1'b1});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0010, 32'h55555555, Z, 1'b1});
      tbl.push_back('{3'b001, NO, Z, NO, Z, Z, 4'h0, 32'h66666666, NO, Z, Z, 4'h0, 4'b1000, 32'h66666666, Z, 1'b1});
      tbl.push_back('{3'b000, RD, 32'h70, NO, Z, Z, 4'h0, Z, RD, 32'h70, Z, 4'h0, 4'b0010, 32'h66666666, Z, 1'b1});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0010, 32'h66666666, Z, 1'b1});
      tbl.push_back('{3'b001, RD, 32'h74, NO, Z, Z, 4'h0, 32'h77777777, RD, 32'h74, Z, 4'h0, 4'b1010, 32'h77777777, Z, 1'b1});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0010, 32'h77777777, Z, 1'b1});
      tbl.push_back('{3'b001, NO, Z, NO, Z, Z, 4'h0, 32'h88888888, NO, Z, Z, 4'h0, 4'b1000, 32'h88888888, Z, 1'b1});
      tbl.push_back('{3'b000, NO, Z, 2'b11, 32'h300, 32'h9, 4'h3, Z, RD, 32'h300, 32'h9, 4'h3, 4'b0001, 32'h88888888, Z, 1'b1});
      tbl.push_back('{3'b000, NO, Z, NO, Z, Z, 4'h0, Z, NO, Z, Z, 4'h0, 4'b0001, 32'h88888888, Z, 1'b1});
      tbl.push_back('{3'b001, NO, Z, NO, Z, Z, 4'h0, 32'hBBBBBBBB, NO, Z, Z, 4'h0, 4'b0100, 32'h88888888, 32'hBBBBBBBB, 1'b1});
      tbl.push_back('{3'b001, NO, Z, NO, Z, Z, 4'h0, 32'hFFFFFFFF, NO, Z, Z, 4'h0, 4'b0000, 32'h88888888, 32'hBBBBBBBB, 1'b1});

      foreach (tbl[i]) begin
         rst          = tbl[i].ctl[2];
         mem_busy     = tbl[i].ctl[1];
         mem_done     = tbl[i].ctl[0];
         mem_r_data_i = tbl[i].rd;
         p0_rw_flag_i = tbl[i].f0;  p0_addr_i = tbl[i].a0;  p0_w_data_i = Z; p0_w_mask_i = 4'h0;
         p1_rw_flag_i = tbl[i].f1;  p1_addr_i = tbl[i].a1;
         p1_w_data_i  = tbl[i].wd1; p1_w_mask_i = tbl[i].m1;
         tick();
         chk($sformatf("v%0d_mem_flag", i), 32'(mem_rw_flag_o), 32'(tbl[i].ef));
         chk($sformatf("v%0d_mem_addr", i), mem_addr_o, tbl[i].ea);
         chk($sformatf("v%0d_mem_wdata", i), mem_w_data_o, tbl[i].ewd);
         chk($sformatf("v%0d_mem_mask", i), 32'(mem_w_mask_o), 32'(tbl[i].em));
         chk($sformatf("v%0d_done_busy", i), 32'({p0_done_o, p1_done_o, p0_busy_o, p1_busy_o}), 32'(tbl[i].edb));
         chk($sformatf("v%0d_p0_rdata", i), p0_r_data_o, tbl[i].er0);
         chk($sformatf("v%0d_p1_rdata", i), p1_r_data_o, tbl[i].er1);
         chk($sformatf("v%0d_overflow", i), 32'(overflow_o), 32'(tbl[i].eovf));
      end
      idle_inputs();
      rst = 1'b0;

      // mem_busy hold: p1 read stays presented, a later p0 request must not steal the grant
      mem_busy = 1'b1;
      p1_rw_flag_i = RD; p1_addr_i = 32'h200;
      tick();
      p1_rw_flag_i = NO; p1_addr_i = Z;
      chk_mem("hold_first", RD, 32'h200);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin p0_rw_flag_i = RD; p0_addr_i = 32'h400; end
         tick();
         p0_rw_flag_i = NO; p0_addr_i = Z;
         chk_mem($sformatf("hold%0d", i), RD, 32'h200);
      end
      mem_busy = 1'b0;
      tick();
      chk_mem("hold_accept", NO, Z);
      tick();
      chk_mem("hold_no_reissue", NO, Z);
      chk("hold_p0_pending", 32'(p0_busy_o), 32'h1);
      mem_done = 1'b1; mem_r_data_i = 32'h20202020;
      tick();
      mem_done = 1'b0; mem_r_data_i = Z;
      chk("hold_p1_done", 32'(p1_done_o), 32'h1);
      chk("hold_p1_rdata", p1_r_data_o, 32'h20202020);
      chk_mem("hold_next_p0", RD, 32'h400);
      tick();
      chk("hold_p1_done_once", 32'(p1_done_o), 32'h0);
      mem_done = 1'b1; mem_r_data_i = 32'h40404040;
      tick();
      mem_done = 1'b0; mem_r_data_i = Z;
      chk("hold_p0_done", 32'(p0_done_o), 32'h1);
      chk("hold_p0_rdata", p0_r_data_o, 32'h40404040);

      // reset while waiting on memory: slots dropped, late mem_done ignored
      p0_rw_flag_i = RD; p0_addr_i = 32'h40;
      tick();
      p0_rw_flag_i = NO; p0_addr_i = Z;
      tick();
      chk_mem("rw_in_wait", NO, Z);
      chk("rw_busy_before", 32'(p0_busy_o), 32'h1);
      rst = 1'b1;
      #2;
      chk("rw_async_outs", 32'({p0_done_o, p1_done_o, p0_busy_o, p1_busy_o, overflow_o}), 32'h0);
      chk("rw_async_rdata", p0_r_data_o | p1_r_data_o, Z);
      rst = 1'b0;
      mem_done = 1'b1; mem_r_data_i = 32'hDEAD0000;
      tick();
      mem_done = 1'b0; mem_r_data_i = Z;
      chk("rw_late_done", 32'({p0_done_o, p1_done_o, p0_busy_o, p1_busy_o}), 32'h0);
      chk("rw_late_rdata", p0_r_data_o, Z);
      chk_mem("rw_late_mem", NO, Z);
      p0_rw_flag_i = RD; p0_addr_i = 32'h10;
      tick();
      p0_rw_flag_i = NO; p0_addr_i = Z;
      chk_mem("rw_idle_issue", RD, 32'h10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
